// File: rtl/flit_check_sink.sv
// flit_check_sink: per-VC buffered network sink with LFSR-paced consumption, credit return and packet checking
module flit_check_sink #(
  parameter int num_vcs = 4,
  parameter int buffer_depth = 8,
  parameter int consume_rate = 1024,
  parameter logic [15:0] lfsr_seed = 16'hACE1,
  parameter int num_routers = 16,
  parameter int seq_width = 8,
  parameter int len_width = 4,
  parameter int flit_data_width = 64,
  parameter int count_width = 32,
  localparam int vc_idx_width = num_vcs > 1 ? $clog2(num_vcs) : 1,
  localparam int src_idx_width = num_routers > 1 ? $clog2(num_routers) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [src_idx_width-1:0]   router_address,
  input  logic                       flit_valid_in,
  input  logic                       flit_head_in,
  input  logic                       flit_tail_in,
  input  logic [vc_idx_width-1:0]    flit_vc_in,
  input  logic [flit_data_width-1:0] flit_data_in,
  output logic                       credit_valid_out,
  output logic [vc_idx_width-1:0]    credit_vc_out,
  output logic                       pkt_done_valid,
  output logic [src_idx_width-1:0]   pkt_done_src,
  output logic [seq_width-1:0]       pkt_done_seq,
  output logic [count_width-1:0]     flit_count,
  output logic [count_width-1:0]     packet_count,
  output logic [4:0]                 error_flags,
  output logic                       error
);
  localparam int ptr_width = buffer_depth > 1 ? $clog2(buffer_depth) : 1;
  localparam int fill_width = ptr_width + 1;
  localparam int hdr_width = 2 * src_idx_width + seq_width + len_width;
  typedef enum logic {idle, body} state_t;
  logic [hdr_width+1:0] mem [num_vcs][buffer_depth];
  logic [ptr_width-1:0] rd_ptr [num_vcs];
  logic [ptr_width-1:0] wr_ptr [num_vcs];
  logic [fill_width-1:0] fill [num_vcs];
  state_t state [num_vcs];
  logic [src_idx_width-1:0] src_l [num_vcs];
  logic [seq_width-1:0] seq_l [num_vcs];
  logic [len_width-1:0] len_l [num_vcs];
  logic [len_width-1:0] cnt_l [num_vcs];
  logic [seq_width-1:0] expected [num_routers];
  logic [15:0] lfsr;
  logic [vc_idx_width-1:0] rr_ptr, grant;
  logic consume, pop, push_ok, done;
  logic e_over, e_frame, e_len, e_seq, e_dest;
  logic [hdr_width+1:0] pf;
  logic p_head, p_tail;
  logic [src_idx_width-1:0] h_src, h_dest, c_src;
  logic [seq_width-1:0] h_seq, c_seq;
  logic [len_width-1:0] h_len;
  logic unused_data;
  assign unused_data = ^flit_data_in[flit_data_width-1:hdr_width];
  assign consume = 32'(lfsr[9:0]) < 32'(consume_rate);
  assign e_over = flit_valid_in && fill[flit_vc_in] == fill_width'(buffer_depth) && !(pop && grant == flit_vc_in);
  assign push_ok = flit_valid_in && !e_over;
  assign pf = mem[grant][rd_ptr[grant]];
  assign p_head = pf[hdr_width+1];
  assign p_tail = pf[hdr_width];
  assign h_src = pf[src_idx_width-1:0];
  assign h_dest = pf[src_idx_width +: src_idx_width];
  assign h_seq = pf[2*src_idx_width +: seq_width];
  assign h_len = pf[2*src_idx_width+seq_width +: len_width];
  assign e_seq = done && c_seq != expected[c_src];
  assign error = |error_flags;
  // round-robin grant: lowest offset from rr_ptr among non-empty VCs wins
  always_comb begin
    pop = 1'b0;
    grant = '0;
    for (int i = num_vcs - 1; i >= 0; i--) begin
      int k;
      k = (int'(rr_ptr) + i) % num_vcs;
      if (fill[k] != '0) begin
        pop = consume;
        grant = vc_idx_width'(k);
      end
    end
  end
  // packet framing/length/destination checks on the popped flit
  always_comb begin
    done = 1'b0;
    c_src = src_l[grant];
    c_seq = seq_l[grant];
    e_frame = 1'b0;
    e_len = 1'b0;
    e_dest = 1'b0;
    if (pop) begin
      if (p_head) begin
        e_frame = state[grant] == body;
        e_dest = h_dest != router_address;
        c_src = h_src;
        c_seq = h_seq;
        e_len = p_tail && h_len != len_width'(1);
        done = p_tail;
      end else if (state[grant] == idle) begin
        e_frame = 1'b1;
      end else if (p_tail) begin
        e_len = len_width'(cnt_l[grant] + 1'b1) != len_l[grant];
        done = 1'b1;
      end
    end
  end
  // flit storage, no reset needed since occupancy gates every read
  always_ff @(posedge clk)
    if (push_ok) mem[flit_vc_in][wr_ptr[flit_vc_in]] <= {flit_head_in, flit_tail_in, flit_data_in[hdr_width-1:0]};
  // per-VC FIFO pointers and packet FSM
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int v = 0; v < num_vcs; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        fill[v] <= '0;
        state[v] <= idle;
        src_l[v] <= '0;
        seq_l[v] <= '0;
        len_l[v] <= '0;
        cnt_l[v] <= '0;
      end
    end else begin
      for (int v = 0; v < num_vcs; v++) begin
        logic pu, po;
        pu = push_ok && flit_vc_in == vc_idx_width'(v);
        po = pop && grant == vc_idx_width'(v);
        wr_ptr[v] <= pu ? wr_ptr[v] + 1'b1 : wr_ptr[v];
        rd_ptr[v] <= po ? rd_ptr[v] + 1'b1 : rd_ptr[v];
        fill[v] <= fill[v] + fill_width'(pu) - fill_width'(po);
        if (po && p_head) begin
          src_l[v] <= h_src;
          seq_l[v] <= h_seq;
          len_l[v] <= h_len;
          cnt_l[v] <= len_width'(1);
          state[v] <= p_tail ? idle : body;
        end else if (po && state[v] == body) begin
          state[v] <= p_tail ? idle : body;
          cnt_l[v] <= cnt_l[v] + 1'b1;
        end
      end
    end
  // LFSR, arbiter pointer, sequence table, registered outputs and sticky flags
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      lfsr <= lfsr_seed;
      rr_ptr <= '0;
      for (int r = 0; r < num_routers; r++) expected[r] <= '0;
      credit_valid_out <= 1'b0;
      credit_vc_out <= '0;
      pkt_done_valid <= 1'b0;
      pkt_done_src <= '0;
      pkt_done_seq <= '0;
      flit_count <= '0;
      packet_count <= '0;
      error_flags <= '0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      rr_ptr <= pop ? vc_idx_width'((int'(grant) + 1) % num_vcs) : rr_ptr;
      if (done) expected[c_src] <= c_seq + 1'b1;
      credit_valid_out <= pop;
      credit_vc_out <= pop ? grant : '0;
      pkt_done_valid <= done;
      pkt_done_src <= done ? c_src : '0;
      pkt_done_seq <= done ? c_seq : '0;
      flit_count <= flit_count + count_width'(pop);
      packet_count <= packet_count + count_width'(done);
      error_flags <= error_flags | {e_dest, e_seq, e_len, e_frame, e_over};
    end
endmodule

// File: tb/tb_flit_check_sink.sv
// tb_flit_check_sink: directed checks of credits, completion records, error flags and paced consumption
module tb_flit_check_sink;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] addr = 4'd5;
  logic v_f = 1'b0, v_z = 1'b0, v_h = 1'b0;
  logic fhd = 1'b0, ftl = 1'b0;
  logic [1:0] fvc = '0;
  logic [63:0] fdat = '0;
  logic cv_f, cv_z, cv_h, dv_f, dv_z, dv_h, er_f, er_z, er_h;
  logic [1:0] cvc_f, cvc_z, cvc_h;
  logic [3:0] ds_f, ds_z, ds_h;
  logic [7:0] dq_f, dq_z, dq_h;
  logic [31:0] fc_f, fc_z, fc_h, pc_f, pc_z, pc_h;
  logic [4:0] ef_f, ef_z, ef_h;
  int checks = 0, errors = 0;
  int sent, got, rr, sel, hs, cred [4];
  logic [7:0] hseq [16];
  logic [7:0] sq [4];

  always #5 clk = ~clk;

  flit_check_sink #(.consume_rate(1024)) dut_f (
    .clk(clk), .reset(reset), .router_address(addr), .flit_valid_in(v_f), .flit_head_in(fhd),
    .flit_tail_in(ftl), .flit_vc_in(fvc), .flit_data_in(fdat), .credit_valid_out(cv_f),
    .credit_vc_out(cvc_f), .pkt_done_valid(dv_f), .pkt_done_src(ds_f), .pkt_done_seq(dq_f),
    .flit_count(fc_f), .packet_count(pc_f), .error_flags(ef_f), .error(er_f));
  flit_check_sink #(.consume_rate(0)) dut_z (
    .clk(clk), .reset(reset), .router_address(addr), .flit_valid_in(v_z), .flit_head_in(fhd),
    .flit_tail_in(ftl), .flit_vc_in(fvc), .flit_data_in(fdat), .credit_valid_out(cv_z),
    .credit_vc_out(cvc_z), .pkt_done_valid(dv_z), .pkt_done_src(ds_z), .pkt_done_seq(dq_z),
    .flit_count(fc_z), .packet_count(pc_z), .error_flags(ef_z), .error(er_z));
  flit_check_sink #(.consume_rate(512)) dut_h (
    .clk(clk), .reset(reset), .router_address(addr), .flit_valid_in(v_h), .flit_head_in(fhd),
    .flit_tail_in(ftl), .flit_vc_in(fvc), .flit_data_in(fdat), .credit_valid_out(cv_h),
    .credit_vc_out(cvc_h), .pkt_done_valid(dv_h), .pkt_done_src(ds_h), .pkt_done_seq(dq_h),
    .flit_count(fc_h), .packet_count(pc_h), .error_flags(ef_h), .error(er_h));

  function automatic logic [63:0] hd(input int src, input int dest, input int seq, input int len);
    return {40'd0, 4'(len), 8'(seq), 4'(dest), 4'(src)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int who, input int vc, input logic h, input logic t, input logic [63:0] d);
    v_f = who == 0;
    v_z = who == 1;
    v_h = who == 2;
    fvc = 2'(vc);
    fhd = h;
    ftl = t;
    fdat = d;
    step();
    v_f = 1'b0;
    v_z = 1'b0;
    v_h = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    sq = '{8'd0, 8'd1, 8'd3, 8'd4};
    do_reset();
    chk("rst_flags", ef_f, 0);
    chk("rst_error", er_f, 0);
    chk("rst_credit", cv_f, 0);
    chk("rst_done", dv_f, 0);
    chk("rst_fcnt", fc_f, 0);
    chk("rst_pcnt", pc_f, 0);
    // zero-rate sink: ninth flit into a depth-8 VC overflows, nothing ever consumed
    for (int i = 0; i < 9; i++) begin
      drive(1, 0, 1'b1, 1'b1, hd(1, 5, i, 1));
      chk($sformatf("ovf_flags_%0d", i), ef_z, i == 8 ? 5'b00001 : 5'b00000);
      chk($sformatf("ovf_nocredit_%0d", i), cv_z, 0);
    end
    chk("ovf_fcnt", fc_z, 0);
    // four-flit packet on VC1: credits start two cycles after the head push
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, i == 0, i == 3, i == 0 ? hd(3, 5, 0, 4) : 64'(i));
      chk($sformatf("p4_credit_%0d", i), cv_f, i > 0);
      if (i > 0) chk($sformatf("p4_vc_%0d", i), cvc_f, 1);
    end
    step();
    chk("p4_credit_last", cv_f, 1);
    chk("p4_vc_last", cvc_f, 1);
    chk("p4_done", dv_f, 1);
    chk("p4_src", ds_f, 3);
    chk("p4_seq", dq_f, 0);
    step();
    chk("p4_credit_off", cv_f, 0);
    chk("p4_done_off", dv_f, 0);
    chk("p4_fcnt", fc_f, 4);
    chk("p4_pcnt", pc_f, 1);
    chk("p4_error", er_f, 0);
    // single-flit packets on VC0..3
    for (int i = 0; i < 5; i++) begin
      if (i < 4) drive(0, i, 1'b1, 1'b1, hd(6 + i, 5, 0, 1));
      else step();
      if (i > 0) begin
        chk($sformatf("rr_credit_%0d", i), cv_f, 1);
        chk($sformatf("rr_vc_%0d", i), cvc_f, i - 1);
        chk($sformatf("rr_done_%0d", i), dv_f, 1);
        chk($sformatf("rr_src_%0d", i), ds_f, 5 + i);
      end
    end
    step();
    chk("rr_pcnt", pc_f, 5);
    chk("rr_flags", ef_f, 0);
    // sequence gap from src 2: 0,1,3 flags, 4 follows the resynchronised expectation
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1'b1, 1'b1, hd(2, 5, sq[i], 1));
      step();
      chk($sformatf("seq_seqno_%0d", i), dq_f, sq[i]);
      chk($sformatf("seq_flags_%0d", i), ef_f, i < 2 ? 5'b00000 : 5'b01000);
    end
    do_reset();
    chk("rst2_flags", ef_f, 0);
    chk("rst2_fcnt", fc_f, 0);
    drive(0, 2, 1'b1, 1'b0, hd(4, 5, 0, 3));
    drive(0, 2, 1'b0, 1'b1, 64'd0);
    step();
    chk("len_flags", ef_f, 5'b00100);
    chk("len_done", dv_f, 1);
    drive(0, 3, 1'b0, 1'b0, 64'd0);
    step();
    chk("frame_flags", ef_f, 5'b00110);
    drive(0, 1, 1'b1, 1'b1, hd(10, 9, 0, 1));
    step();
    chk("dest_flags", ef_f, 5'b10110);
    chk("dest_error", er_f, 1);
    chk("dest_fcnt", fc_f, 4);
    chk("dest_pcnt", pc_f, 2);
    // half-rate sink under credit-limited saturating traffic
    sent = 0;
    got = 0;
    rr = 0;
    hs = 0;
    for (int v = 0; v < 4; v++) cred[v] = 8;
    for (int s = 0; s < 16; s++) hseq[s] = '0;
    chk("half_start_fcnt", fc_h, 0);
    for (int c = 0; c < 10000; c++) begin
      sel = -1;
      for (int k = 0; k < 4; k++)
        if (sel < 0 && cred[(rr + k) % 4] > 0) sel = (rr + k) % 4;
      if (sel >= 0) begin
        v_h = 1'b1;
        fvc = 2'(sel);
        fhd = 1'b1;
        ftl = 1'b1;
        fdat = hd(hs, 5, hseq[hs], 1);
        hseq[hs] = hseq[hs] + 1'b1;
        hs = (hs + 1) % 16;
        cred[sel]--;
        sent++;
        rr = (sel + 1) % 4;
      end else v_h = 1'b0;
      step();
      if (cv_h) begin
        got++;
        cred[cvc_h]++;
      end
    end
    v_h = 1'b0;
    chk("half_rate_window", fc_h >= 4500 && fc_h <= 5500, 1);
    chk("half_credits_eq_pops", got, fc_h);
    chk("half_outstanding_le_capacity", sent - got <= 32, 1);
    for (int c = 0; c < 2000 && got != sent; c++) begin
      step();
      if (cv_h) got++;
    end
    chk("half_no_credit_loss", got, sent);
    chk("half_pcnt", pc_h, fc_h);
    chk("half_error", er_h, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/flit_check_sink.md
Name: flit_check_sink

Overview:
- Parametrised network-terminal sink for mesh testbenches. Successor to the earlier single-rate sink.
- Receives decoded flits from a router ejection port into per-VC buffers and consumes them at a programmable rate using a synthesizable LFSR.
- Returns one credit per consumed flit and checks every packet for framing, payload length, destination and per-source sequence order.
- Exposes sticky error flags, flit/packet counters and a per-packet completion record for the scoreboard.

Parameters:
- num_vcs, 4, number of virtual channels; vc_idx_width = clogb(num_vcs).
- buffer_depth, 8, flits per VC buffer (power of 2, >=2).
- consume_rate, 1024, consumption probability in 1/1024 units; 0 = never, 1024 = every cycle.
- lfsr_seed, 16'hACE1, nonzero LFSR reset value.
- num_routers, 16, number of network nodes; src_idx_width = clogb(num_routers).
- seq_width, 8, sequence-number width; sequence wraps mod 2^seq_width.
- len_width, 4, payload-length field width.
- flit_data_width, 64, flit data width (>= src_idx_width*2 + seq_width + len_width).
- count_width, 32, statistics counter width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- router_address  input  src_idx_width  this node's address.
- flit_valid_in  input  1  flit present this cycle.
- flit_head_in  input  1  head flit.
- flit_tail_in  input  1  tail flit (head+tail = single-flit packet).
- flit_vc_in  input  vc_idx_width  target VC.
- flit_data_in  input  flit_data_width  data. Head-flit layout, LSB upward: src[src_idx_width], dest[src_idx_width], seq[seq_width], len[len_width] (total flits, 1..2^len_width-1).
- credit_valid_out  output  1  one credit returned.
- credit_vc_out  output  vc_idx_width  VC of returned credit.
- pkt_done_valid  output  1  packet completed (tail consumed).
- pkt_done_src  output  src_idx_width  source of completed packet.
- pkt_done_seq  output  seq_width  sequence of completed packet.
- flit_count  output  count_width  total flits consumed.
- packet_count  output  count_width  total packets consumed.
- error_flags  output  5  sticky: [0] overflow, [1] framing, [2] length, [3] sequence, [4] destination.
- error  output  1  OR of error_flags.

Behaviour:
- Reset: all outputs 0, all buffers empty, LFSR = lfsr_seed, expected-sequence table all 0, all per-VC FSMs in IDLE, arbiter pointer at VC0.
- Push:
  - A flit with flit_valid_in at cycle t is written into FIFO[flit_vc_in] at the t edge and is visible for pop from cycle t+1. There is no bypass.
  - If the VC holds buffer_depth flits and is not popped in the same cycle, the flit is dropped and error_flags[0] sets.
  - Push and pop to a full VC in the same cycle is legal.
- Consume:
  - 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - consume = (lfsr[9:0] < consume_rate).
  - When consume is high and at least one VC is non-empty, a round-robin arbiter grants one non-empty VC and pops its head flit that cycle.
  - The arbiter pointer advances to the VC after the granted one, only on a grant.
- Credit: a pop at cycle p drives credit_valid_out=1 and credit_vc_out=popped VC at cycle p+1, registered. At most one credit per cycle.
- Per-VC packet FSM, evaluated on pops:
  - IDLE + head: latch src, seq, len, flit_cnt=1.
    - Check dest == router_address; on mismatch set [4].
    - If tail is also set, check len==1 (else set [2]), complete, stay IDLE.
    - Otherwise go to BODY.
  - IDLE + non-head: set [1], discard, stay IDLE.
  - BODY + head: set [1], abandon the old packet (no completion), restart as IDLE + head.
  - BODY + non-tail: flit_cnt+1.
  - BODY + tail: check flit_cnt+1 == len (else set [2]), complete, go to IDLE.
- Completion at pop cycle p:
  - Compare latched seq with expected[src]; on mismatch set [3].
  - expected[src] <= latched seq + 1 mod 2^seq_width, resynchronising after an error.
  - At p+1: pkt_done_valid=1 with src and seq; packet_count+1.
- flit_count increments on every pop, including discarded flits. Both counters wrap silently at 2^count_width.
- Error flags are sticky until reset. error is combinational OR of the flags.
- Reset mid-packet: all state is cleared immediately (asynchronous). Credits not yet returned are lost; the sender must be reset together with this block.

Test Plan:
- consume_rate=1024: one 4-flit packet (src=3, dest=router_address=5, seq=0, len=4) on VC1 → 4 credits on VC1 in consecutive cycles, first credit 2 cycles after the head is pushed. pkt_done src=3 seq=0. flit_count=4, packet_count=1, error=0.
- consume_rate=0: 9 flits pushed to VC0 with buffer_depth=8 → zero credits; error_flags=5'b00001 after the 9th push.
- Interleaved single-flit packets on VC0..VC3, all pending, consume_rate=1024 → credits in VC order 0,1,2,3; 4 pkt_done pulses.
- src=2 sends seq 0,1,3 → error_flags[3] set on the third completion. A following seq=4 raises no new error.
- Head with len=3 followed by tail after 2 flits → [2] set. Body flit arriving in IDLE → [1] set. Head with dest≠router_address → [4] set.
- consume_rate=512 over 10000 cycles of saturating traffic → consumed-flit fraction within 45–55%, no credit loss (sent - credited = occupancy), error=0.
